// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
   parameter int xlen = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [xlen-1:0] a,
   input  logic [xlen-1:0] b,
   input  logic            borrow_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [xlen-1:0] diff,
   output logic            borrow_out,
   output logic            overflow
);

   localparam int cw = (xlen > 1) ? $clog2(xlen) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [xlen-1:0] a_sh;
   logic [xlen-1:0] b_sh;
   logic [xlen-1:0] diff_r;
   logic [cw-1:0]   cnt;
   logic            br;
   logic            a_i;
   logic            b_i;
   logic            d;
   logic            br_next;
   logic            last_bit;

   // Single full-subtractor cell working on the current LSBs.
   assign a_i      = a_sh[0];
   assign b_i      = b_sh[0];
   assign d        = a_i ^ b_i ^ br;
   assign br_next  = (~a_i & b_i) | (~a_i & br) | (b_i & br);
   assign last_bit = (cnt == cw'(xlen - 1));
   assign diff     = diff_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         br         <= 1'b0;
         a_sh       <= '0;
         b_sh       <= '0;
         diff_r     <= '0;
         borrow_out <= 1'b0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  br       <= borrow_in;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               // Result bits enter at the MSB so bit 0 lands at diff[0] after xlen shifts.
               diff_r <= (diff_r >> 1) | (xlen'(d) << (xlen - 1));
               br     <= br_next;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  borrow_out <= br_next;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   // Signed overflow: borrow into the MSB differs from borrow out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (state == RUN && last_bit) begin
         overflow <= br ^ br_next;
      end
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: accepted requests push expected results,
// an output monitor pops and compares, also checking latency and initiation interval.
module tb_serial_subtractor;

   localparam int XLEN = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [XLEN-1:0] a = '0;
   logic [XLEN-1:0] b = '0;
   logic            borrow_in = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [XLEN-1:0] diff;
   logic            borrow_out;
   logic            overflow;

   serial_subtractor #(.xlen(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .borrow_in(borrow_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] diff;
      logic            bo;
      logic            ovf;
      int              acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   b2b_mode = 0;
   int   last_rise = -1;
   bit   prev_ov = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                  input logic bi, input int acc);
      exp_t e;
      int   ud;
      int   sd;
      logic [31:0] udv;
      ud     = int'(x) - int'(y) - int'(bi);
      udv    = ud;
      e.diff = udv[XLEN-1:0];
      e.bo   = (int'(x) < int'(y) + int'(bi));
      sd     = int'($signed(x)) - int'($signed(y)) - int'(bi);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      e.ovf  = (sd < -(2 ** (XLEN - 1))) || (sd > (2 ** (XLEN - 1)) - 1);
`else
      e.ovf  = 1'b0;
      if (sd == 0) e.ovf = 1'b0;
`endif
      e.acc_cyc = acc;
      return e;
   endfunction

   // Acceptance monitor: a handshake seen here completes at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready)
         sb.push_back(model(a, b, borrow_in, cyc + 1));
   end

   // Output monitor.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 0;
      end else begin
         if (out_valid) begin
            chk("in_ready_low_in_done", in_ready, 0);
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", out_valid, 0);
            end else begin
               if (!prev_ov) begin
                  chk("latency", cyc - sb[0].acc_cyc, XLEN);
                  if (b2b_mode) begin
                     if (last_rise >= 0) chk("initiation_interval", cyc - last_rise, XLEN + 2);
                     last_rise = cyc;
                  end
               end
               chk("diff", diff, sb[0].diff);
               chk("borrow_out", borrow_out, sb[0].bo);
               chk("overflow", overflow, sb[0].ovf);
               if (out_ready) void'(sb.pop_front());
            end
         end
         prev_ov = out_valid;
      end
   end

   task automatic send(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic bi, input bit keep);
      int n;
      in_valid  = 1'b1;
      a         = x;
      b         = y;
      borrow_in = bi;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk(nm, sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow_out", borrow_out, 0);
      chk("rst_overflow", overflow, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors
      send(8'h05, 8'h03, 1'b0, 0);
      send(8'h03, 8'h05, 1'b0, 0);
      send(8'h00, 8'h00, 1'b1, 0);
      send(8'h80, 8'h01, 1'b0, 0);
      send(8'h7F, 8'hFF, 1'b0, 0);
      drain("directed_drain");

      // Backpressure with ignored in_valid pulses during RUN and DONE
      out_ready = 1'b0;
      send(8'hA0, 8'h0A, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 8'hFF; b = 8'h11;
         #2 chk("in_ready_low_in_run", in_ready, 0);
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("bp_out_valid_seen", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         @(posedge clk);
         #1;
         chk("bp_held_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_out_valid", out_valid, 0);
      chk("bp_queue_empty", sb.size(), 0);

      // Reset mid-RUN
      send(8'h33, 8'h22, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_diff", diff, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(8'h10, 8'h01, 1'b0, 0);
      drain("post_reset_drain");

      // Back-to-back with in_valid held high
      b2b_mode = 1;
      last_rise = -1;
      send(8'h44, 8'h11, 1'b0, 1);
      send(8'h12, 8'h34, 1'b1, 1);
      send(8'h99, 8'h66, 1'b0, 0);
      drain("b2b_drain");
      b2b_mode = 0;

      // Random transactions with random backpressure
      fork
         begin
            for (int i = 0; i < 40; i++)
               send(XLEN'($urandom), XLEN'($urandom), 1'($urandom), 1'($urandom));
            in_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 600; i++) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join_any
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         #1 out_ready = ($urandom_range(0, 3) != 0);
         n++;
      end
      out_ready = 1'b1;
      drain("random_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
